wave_capture_mc: RTL
====================

# wave_capture_mc

Parametrised multi-channel successor to the single-channel wave capture used by the wave display path. It captures CHANNELS signed audio streams in lock-step into one half of a double-buffered sample RAM while the display reads the other half. Capture is gated by a selectable trigger (rising or falling zero-cross on a chosen channel, free-run, or single-shot) with programmable decimation. It sits between the codec sample strobe and `ram_1w2r`; the RAM word holds all channels side by side.

## Interface
- CHANNELS, 2, number of parallel sample channels (1..8)
- SAMPLE_WIDTH, 16, input sample width per channel, two's complement
- STORE_WIDTH, 8, stored width per channel (≤ SAMPLE_WIDTH)
- ADDR_WIDTH, 8, index bits per buffer half; 2^ADDR_WIDTH entries per half
- CH_SEL_WIDTH, 3, width of trigger_channel
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- new_sample_ready  in  1  one-cycle strobe, new_sample_in valid
- new_sample_in  in  CHANNELS*SAMPLE_WIDTH  channel k in bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- trigger_mode  in  2  00 rising, 01 falling, 10 free-run, 11 single-shot rising
- trigger_channel  in  CH_SEL_WIDTH  channel whose sign drives the trigger; ≥CHANNELS means channel 0
- decimation  in  4  store one of every decimation+1 accepted strobes
- arm  in  1  one-cycle pulse, re-arms from HOLD
- wave_display_idle  in  1  high while display is not reading RAM
- write_address  out  ADDR_WIDTH+1  {~read_index, index}
- write_enable  out  1  one-cycle RAM write strobe
- write_sample  out  CHANNELS*STORE_WIDTH  offset-binary samples, channel k at [k*STORE_WIDTH +: STORE_WIDTH]
- read_index  out  1  buffer half the display reads
- capture_done  out  1  one-cycle pulse when buffers swap
- state_out  out  2  current state for debug

## Operation
- States: ARMED(00), ACTIVE(01), WAIT(10), HOLD(11).
- Accept: strobe with dec_cnt==0 is accepted, dec_cnt loads decimation; a strobe with dec_cnt≠0 decrements it. The counter runs only in ARMED/ACTIVE and is cleared to 0 on entry to ARMED.
- Stored value per channel: top STORE_WIDTH bits of the sample with MSB inverted (0x8000→0x00, 0x0000→0x80, 0x7FFF→0xFF).
- prev_sign: sign bit of the trigger channel, updated on every accepted sample in ARMED. Cleared to 0 on reset and on entry to ARMED.
- ARMED, accepted sample:
  - Rising/single-shot: trigger when prev_sign=1 and cur sign=0.
  - Falling: trigger when prev_sign=0 and cur sign=1.
  - Free-run: trigger always.
  - On trigger, the triggering sample is written at index 0, index←1, go ACTIVE. trigger_mode and trigger_channel are read only in ARMED.
- ACTIVE, accepted sample: write at index, index increments. A write at index 2^ADDR_WIDTH−1 wraps index to 0 and goes to WAIT.
- WAIT: no writes; strobes ignored. When wave_display_idle=1: toggle read_index, pulse capture_done, then go to HOLD if trigger_mode==11, else ARMED.
- HOLD: no writes; on arm=1 go to ARMED. An arm pulse in any other state is ignored.
- Reset mid-capture: immediate return to ARMED, index 0, read_index 0. The partial buffer is abandoned.

## Timing
- Reset values: write_enable 0, write_address 0, write_sample 0, read_index 0, capture_done 0, state_out 00. Internal index 0, dec_cnt 0, prev_sign 0.
- All outputs are registered. write_enable, write_address and write_sample are valid together in the cycle after the accepted strobe, for exactly one cycle.
- Strobes closer than 2 cycles apart are not supported.
- read_index toggles and capture_done pulses in the cycle after wave_display_idle is first sampled high in WAIT. The state reaches ARMED/HOLD in that same cycle.
- HOLD→ARMED takes effect the cycle after arm. A strobe coincident with arm is not accepted.
- Strobe coincident with the final ACTIVE write cycle: the write completes, and the next strobe is ignored because the block is now in WAIT.
- Capture of one half takes exactly 2^ADDR_WIDTH writes: 1 trigger write plus 2^ADDR_WIDTH−1 ACTIVE writes.

## Test plan
- Reset, then mode 10, decimation 0, CHANNELS=2, 256 strobes with ch0=0x1234, ch1=0xF000 -> 256 writes at addresses 0x100..0x1FF with data {0x70,0x92}. Then idle=1 -> read_index=1 and a one-cycle capture_done pulse.
- Mode 00, ch0 sequence 0x0100, 0xFF00, 0xFE00, 0x0005 -> no writes until 0x0005, which is written at address 0x100 with data 0x80; state becomes ACTIVE.
- Mode 01, trigger_channel=1, ch1 sequence 0x0010, 0xFFF0 -> trigger on 0xFFF0. Trigger_channel=5 -> behaves as channel 0.
- Decimation 2, free-run, 9 strobes -> writes only for strobes 1, 4 and 7 at indices 0, 1, 2.
- Mode 11: after a full capture and idle=1 -> state HOLD, and 20 further strobes produce no writes. Then arm -> ARMED, and the next rising crossing writes index 0 of the other half.
- Assert reset low at index 100 in ACTIVE -> all outputs return to reset values asynchronously. After release, capture restarts at address 0x100.

Source files
------------

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered wave capture into one half of a double-buffered sample RAM.
// The display reads the other half; halves swap once a full buffer is written and the display is idle.
module wave_capture_mc #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned STORE_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned CH_SEL_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              new_sample_ready,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]  new_sample_in,
  input  logic [1:0]                        trigger_mode,
  input  logic [CH_SEL_WIDTH-1:0]           trigger_channel,
  input  logic [3:0]                        decimation,
  input  logic                              arm,
  input  logic                              wave_display_idle,
  output logic [ADDR_WIDTH:0]               write_address,
  output logic                              write_enable,
  output logic [CHANNELS*STORE_WIDTH-1:0]   write_sample,
  output logic                              read_index,
  output logic                              capture_done,
  output logic [1:0]                        state_out
);

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    ACTIVE = 2'b01,
    WAIT   = 2'b10,
    HOLD   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_RISE   = 2'b00,
    MODE_FALL   = 2'b01,
    MODE_FREE   = 2'b10,
    MODE_SINGLE = 2'b11
  } mode_e;

  localparam logic [STORE_WIDTH-1:0] STORE_MSB = STORE_WIDTH'(1) << (STORE_WIDTH - 1);

  state_e                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            index_q, index_d;
  logic [3:0]                       dec_cnt_q, dec_cnt_d;
  logic                             prev_sign_q, prev_sign_d;
  logic                             read_index_q, read_index_d;
  logic                             capture_done_q, capture_done_d;
  logic                             write_enable_q, write_enable_d;
  logic [ADDR_WIDTH:0]              write_address_q, write_address_d;
  logic [CHANNELS*STORE_WIDTH-1:0]  write_sample_q, write_sample_d;

  logic                             capturing;
  logic                             accept;
  logic                             cur_sign;
  logic                             trigger_hit;
  logic                             last_index;
  logic [CHANNELS*STORE_WIDTH-1:0]  stored;

  // Only the upper STORE_WIDTH bits of each sample are kept.
  logic unused_sample_bits;
  assign unused_sample_bits = ^new_sample_in;

  // Truncate to the top bits and flip the MSB: two's complement to offset binary.
  always_comb begin
    stored = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      stored[k*STORE_WIDTH +: STORE_WIDTH] =
        new_sample_in[k*SAMPLE_WIDTH + SAMPLE_WIDTH - STORE_WIDTH +: STORE_WIDTH] ^ STORE_MSB;
    end
  end

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    cur_sign = new_sample_in[SAMPLE_WIDTH-1];
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(trigger_channel) == k) begin
        cur_sign = new_sample_in[k*SAMPLE_WIDTH + SAMPLE_WIDTH - 1];
      end
    end
  end

  always_comb begin
    trigger_hit = 1'b0;
    case (mode_e'(trigger_mode))
      MODE_RISE, MODE_SINGLE: trigger_hit = prev_sign_q & ~cur_sign;
      MODE_FALL:              trigger_hit = ~prev_sign_q & cur_sign;
      MODE_FREE:              trigger_hit = 1'b1;
      default:                trigger_hit = 1'b0;
    endcase
  end

  assign capturing  = (state_q == ARMED) || (state_q == ACTIVE);
  assign accept     = capturing && new_sample_ready && (dec_cnt_q == '0);
  assign last_index = (index_q == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (accept && trigger_hit) state_d = ACTIVE;
      ACTIVE:  if (accept && last_index)  state_d = WAIT;
      WAIT: begin
        if (wave_display_idle) begin
          state_d = (mode_e'(trigger_mode) == MODE_SINGLE) ? HOLD : ARMED;
        end
      end
      HOLD:    if (arm) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    index_d         = index_q;
    dec_cnt_d       = dec_cnt_q;
    prev_sign_d     = prev_sign_q;
    read_index_d    = read_index_q;
    capture_done_d  = 1'b0;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;

    if (capturing && new_sample_ready) begin
      dec_cnt_d = (dec_cnt_q == '0) ? decimation : dec_cnt_q - 4'd1;
    end

    case (state_q)
      ARMED: begin
        if (accept) begin
          prev_sign_d = cur_sign;
          if (trigger_hit) begin
            write_enable_d  = 1'b1;
            write_address_d = {~read_index_q, {ADDR_WIDTH{1'b0}}};
            write_sample_d  = stored;
            index_d         = ADDR_WIDTH'(1);
          end
        end
      end
      ACTIVE: begin
        // Incrementing past the last entry wraps index back to 0 for the next capture.
        if (accept) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, index_q};
          write_sample_d  = stored;
          index_d         = index_q + ADDR_WIDTH'(1);
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          read_index_d   = ~read_index_q;
          capture_done_d = 1'b1;
        end
      end
      default: ;
    endcase

    if ((state_d == ARMED) && (state_q != ARMED)) begin
      dec_cnt_d   = '0;
      prev_sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q         <= '0;
      dec_cnt_q       <= '0;
      prev_sign_q     <= 1'b0;
      read_index_q    <= 1'b0;
      capture_done_q  <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
    end else begin
      index_q         <= index_d;
      dec_cnt_q       <= dec_cnt_d;
      prev_sign_q     <= prev_sign_d;
      read_index_q    <= read_index_d;
      capture_done_q  <= capture_done_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
    end
  end

  assign write_address = write_address_q;
  assign write_enable  = write_enable_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;
  assign capture_done  = capture_done_q;
  assign state_out     = state_q;

endmodule
